// File: rtl/ram_responder.sv
// Memory-side responder for the RAM_enable / RAM_OpCode / MFC handshake.
// It models a byte-addressed, big-endian RAM with programmable access latency.
module ram_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 3
) (
    input  logic                  Clk,
    input  logic                  RESET,
    input  logic                  RAM_enable,
    input  logic [5:0]            RAM_OpCode,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MFC,
    output logic                  MAE
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH,
            OP_ST, OP_STB, OP_STH: op_legal = 1'b1;
            default:               op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [5:0] op);
        case (op)
            OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH: op_is_load = 1'b1;
            default:                                   op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] lsb);
        case (op)
            OP_LD, OP_ST:            op_misaligned = (lsb != 2'b00);
            OP_LDUH, OP_LDSH, OP_STH: op_misaligned = lsb[0];
            default:                 op_misaligned = 1'b0;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [5:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic [31:0]             dout_q, dout_d;
    logic                    mfc_q, mfc_d;
    logic                    mae_q, mae_d;

    logic [7:0]              mem_q [0:DEPTH-1];

    logic [5:0]              acc_op_s;
    logic [ADDR_WIDTH-1:0]   acc_addr_s;
    logic [31:0]             acc_data_s;
    logic [ADDR_WIDTH-1:0]   lane_addr_s [0:3];
    logic [7:0]              rd_s [0:3];
    logic [7:0]              wb_s [0:3];
    logic [3:0]              lane_we_s;
    logic [3:0]              mem_we_s;
    logic [31:0]             load_val_s;
    logic                    bad_s;
    logic                    do_access_s;

    // In IDLE the access (if it happens at the sample edge) uses the live inputs.
    always_comb begin
        acc_op_s   = (state_q == S_IDLE) ? RAM_OpCode : op_q;
        acc_addr_s = (state_q == S_IDLE) ? Address    : addr_q;
        acc_data_s = (state_q == S_IDLE) ? DataIn     : data_q;
        bad_s      = !op_legal(acc_op_s) || op_misaligned(acc_op_s, acc_addr_s[1:0]);
    end

    // Byte lanes a..a+3 wrap modulo the memory depth; lane 0 is the MSB.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr_s[i] = acc_addr_s + ADDR_WIDTH'(i);
            rd_s[i]        = mem_q[lane_addr_s[i]];
        end
    end

    // Load result formatting and store lane selection.
    always_comb begin
        load_val_s = dout_q;
        lane_we_s  = 4'b0000;
        wb_s[0]    = 8'h00;
        wb_s[1]    = 8'h00;
        wb_s[2]    = 8'h00;
        wb_s[3]    = 8'h00;
        case (acc_op_s)
            OP_LD:   load_val_s = {rd_s[0], rd_s[1], rd_s[2], rd_s[3]};
            OP_LDUB: load_val_s = {24'h000000, rd_s[0]};
            OP_LDSB: load_val_s = {{24{rd_s[0][7]}}, rd_s[0]};
            OP_LDUH: load_val_s = {16'h0000, rd_s[0], rd_s[1]};
            OP_LDSH: load_val_s = {{16{rd_s[0][7]}}, rd_s[0], rd_s[1]};
            OP_ST: begin
                lane_we_s = 4'b1111;
                wb_s[0]   = acc_data_s[31:24];
                wb_s[1]   = acc_data_s[23:16];
                wb_s[2]   = acc_data_s[15:8];
                wb_s[3]   = acc_data_s[7:0];
            end
            OP_STH: begin
                lane_we_s = 4'b0011;
                wb_s[0]   = acc_data_s[15:8];
                wb_s[1]   = acc_data_s[7:0];
            end
            OP_STB: begin
                lane_we_s = 4'b0001;
                wb_s[0]   = acc_data_s[7:0];
            end
            default: load_val_s = dout_q;
        endcase
        mem_we_s = lane_we_s & {4{do_access_s}};
    end

    // Handshake FSM: next state, counter, latches and registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mfc_d       = mfc_q;
        mae_d       = mae_q;
        do_access_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                mfc_d = 1'b0;
                mae_d = 1'b0;
                if (RAM_enable) begin
                    op_d   = RAM_OpCode;
                    addr_d = Address;
                    data_d = DataIn;
                    if (bad_s) begin
                        state_d = S_DONE;
                        cnt_d   = 4'd0;
                        mfc_d   = 1'b1;
                        mae_d   = 1'b1;
                    end else if (LATENCY == 1) begin
                        state_d     = S_DONE;
                        cnt_d       = 4'd0;
                        mfc_d       = 1'b1;
                        do_access_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!RAM_enable) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    mfc_d   = 1'b0;
                    mae_d   = 1'b0;
                end else if (cnt_q == 4'd1) begin
                    state_d     = S_DONE;
                    cnt_d       = 4'd0;
                    mfc_d       = 1'b1;
                    mae_d       = 1'b0;
                    do_access_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!RAM_enable) begin
                    state_d = S_IDLE;
                    mfc_d   = 1'b0;
                    mae_d   = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                mfc_d   = 1'b0;
                mae_d   = 1'b0;
            end
        endcase
        if (do_access_s && op_is_load(acc_op_s)) begin
            dout_d = load_val_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // Control and output registers; the memory array is deliberately not reset.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 6'b000000;
            addr_q  <= '0;
            data_q  <= 32'h00000000;
            dout_q  <= 32'h00000000;
            mfc_q   <= 1'b0;
            mae_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            mae_q   <= mae_d;
        end
    end

    // Byte-wide memory writes, only on the completing edge of a store.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we_s[i]) begin
                mem_q[lane_addr_s[i]] <= wb_s[i];
            end
        end
    end

    assign DataOut = dout_q;
    assign MFC     = mfc_q;
    assign MAE     = mae_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a LATENCY=3 and a LATENCY=1 instance share
// one stimulus bus; sel chooses which instance is enabled and observed.
module tb_ram_responder;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sel;
    logic [5:0]  op;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [31:0] dout3, dout1;
    logic        mfc3, mfc1, mae3, mae1;
    logic        en3_s, en1_s;
    logic [31:0] dout_s;
    logic        mfc_s, mae_s;

    int total;
    int bad;

    assign en3_s  = en & ~sel;
    assign en1_s  = en & sel;
    assign dout_s = sel ? dout1 : dout3;
    assign mfc_s  = sel ? mfc1  : mfc3;
    assign mae_s  = sel ? mae1  : mae3;

    ram_responder #(.ADDR_WIDTH(9), .LATENCY(3)) dut3 (
        .Clk(clk), .RESET(rst_n), .RAM_enable(en3_s), .RAM_OpCode(op),
        .Address(addr), .DataIn(din), .DataOut(dout3), .MFC(mfc3), .MAE(mae3)
    );

    ram_responder #(.ADDR_WIDTH(9), .LATENCY(1)) dut1 (
        .Clk(clk), .RESET(rst_n), .RAM_enable(en1_s), .RAM_OpCode(op),
        .Address(addr), .DataIn(din), .DataOut(dout1), .MFC(mfc1), .MAE(mae1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request: counts edges from the sample edge (inclusive) to MFC,
    // scrambles the inputs after sampling, optionally holds enable, then drops it.
    task automatic access(input string tag, input logic [5:0] o, input logic [8:0] a,
                          input logic [31:0] d, input int exp_edges, input logic exp_mae,
                          input int hold);
        int n;
        int held;
        op   = o;
        addr = a;
        din  = d;
        en   = 1'b1;
        n    = 0;
        while (!mfc_s && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                din  = ~d;
                addr = a ^ 9'h1F0;
                op   = OP_STB;
            end
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_edges));
        check({tag, "_mae"}, {31'd0, mae_s}, {31'd0, exp_mae});
        held = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (mfc_s) held++;
        end
        if (hold > 0) check({tag, "_held"}, 32'(held), 32'(hold));
        en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop"}, {31'd0, mfc_s}, 32'd0);
    endtask

    initial begin
        int seen;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 1'b0;
        op    = 6'b000000;
        addr  = 9'd0;
        din   = 32'h00000000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout_s, 32'h00000000);
        check("rst_mfc", {31'd0, mfc_s}, 32'd0);
        check("rst_mae", {31'd0, mae_s}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stores and loads in every width.
        access("st32",  OP_ST,   9'd32, 32'h00000009, 3, 1'b0, 0);
        access("ld32",  OP_LD,   9'd32, 32'h0,        3, 1'b0, 0);
        check("ld32_val", dout_s, 32'h00000009);
        access("stb40", OP_STB,  9'd40, 32'hFFFFFF80, 3, 1'b0, 0);
        check("stb_keeps_dout", dout_s, 32'h00000009);
        access("ldsb40", OP_LDSB, 9'd40, 32'h0, 3, 1'b0, 0);
        check("ldsb40_val", dout_s, 32'hFFFFFF80);
        access("ldub40", OP_LDUB, 9'd40, 32'h0, 3, 1'b0, 0);
        check("ldub40_val", dout_s, 32'h00000080);
        access("sth42", OP_STH,  9'd42, 32'h12348001, 3, 1'b0, 0);
        access("ldsh42", OP_LDSH, 9'd42, 32'h0, 3, 1'b0, 0);
        check("ldsh42_val", dout_s, 32'hFFFF8001);
        access("lduh42", OP_LDUH, 9'd42, 32'h0, 3, 1'b0, 0);
        check("lduh42_val", dout_s, 32'h00008001);
        access("st44",  OP_ST,   9'd44, 32'hA1B2C3D4, 3, 1'b0, 0);
        access("ldub45", OP_LDUB, 9'd45, 32'h0, 3, 1'b0, 0);
        check("ldub45_val", dout_s, 32'h000000B2);
        access("lduh46", OP_LDUH, 9'd46, 32'h0, 3, 1'b0, 0);
        check("lduh46_val", dout_s, 32'h0000C3D4);
        access("ldsb47", OP_LDSB, 9'd47, 32'h0, 3, 1'b0, 0);
        check("ldsb47_val", dout_s, 32'hFFFFFFD4);
        access("sttop", OP_ST,   9'd508, 32'hDEADBEEF, 3, 1'b0, 0);
        access("ldtop", OP_LD,   9'd508, 32'h0, 3, 1'b0, 0);
        check("ldtop_val", dout_s, 32'hDEADBEEF);

        // Exceptions: misaligned and illegal opcodes answer at the sample edge.
        access("ld34",  OP_LD,   9'd34, 32'h0, 1, 1'b1, 0);
        check("ld34_dout", dout_s, 32'hDEADBEEF);
        access("ldd32", OP_LDD,  9'd32, 32'h0, 1, 1'b1, 0);
        access("sth33", OP_STH,  9'd33, 32'hFFFFFFFF, 1, 1'b1, 0);
        check("exc_dout", dout_s, 32'hDEADBEEF);
        access("ld32b", OP_LD,   9'd32, 32'h0, 3, 1'b0, 0);
        check("exc_mem_unchanged", dout_s, 32'h00000009);

        // Abort: enable dropped after one WAIT edge.
        access("stb50", OP_STB, 9'd50, 32'h0000005C, 3, 1'b0, 0);
        op   = OP_STB;
        addr = 9'd50;
        din  = 32'h000000AA;
        en   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        en   = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (mfc_s) seen++;
        end
        check("abort_no_mfc", 32'(seen), 32'd0);
        access("ldub50", OP_LDUB, 9'd50, 32'h0, 3, 1'b0, 0);
        check("abort_mem_kept", dout_s, 32'h0000005C);

        // Asynchronous reset in the middle of a store.
        access("st64",  OP_ST, 9'd64, 32'h01020304, 3, 1'b0, 0);
        access("ld64a", OP_LD, 9'd64, 32'h0, 3, 1'b0, 0);
        check("ld64a_val", dout_s, 32'h01020304);
        op   = OP_ST;
        addr = 9'd64;
        din  = 32'h12345678;
        en   = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_mfc", {31'd0, mfc_s}, 32'd0);
        check("rstmid_dout", dout_s, 32'h00000000);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access("ld64b", OP_LD, 9'd64, 32'h0, 3, 1'b0, 0);
        check("rstmid_mem_kept", dout_s, 32'h01020304);

        // Held enable: one write only, MFC stays high, new DataIn ignored.
        access("st80h", OP_ST, 9'd80, 32'h11223344, 3, 1'b0, 10);
        access("ld80",  OP_LD, 9'd80, 32'h0, 3, 1'b0, 0);
        check("held_single_write", dout_s, 32'h11223344);

        // Same with the LATENCY=1 instance.
        sel = 1'b1;
        @(posedge clk);
        #1;
        access("l1_st",  OP_ST, 9'd100, 32'hCAFEF00D, 1, 1'b0, 10);
        access("l1_ld",  OP_LD, 9'd100, 32'h0, 1, 1'b0, 0);
        check("l1_ld_val", dout_s, 32'hCAFEF00D);
        access("l1_exc", OP_LDUH, 9'd101, 32'h0, 1, 1'b1, 0);
        check("l1_exc_dout", dout_s, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
